// File: rtl/fp_pkg.sv
// Shared types, flag bit positions and width helpers for the pipelined FP multiplier.
package fp_pkg;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_t;

    // Flag vector layout is {NV, OF, UF, NX}.
    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_NV = 3;
    localparam int FLAG_W  = 4;

    function automatic int fp_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Subnormals (exp==0) are deliberately classed as zero so they flush.
    function automatic fp_class_t fp_classify(input logic exp_zero, input logic exp_max,
                                              input logic man_zero);
        if (exp_zero)
            return FP_ZERO;
        else if (exp_max)
            return man_zero ? FP_INF : FP_NAN;
        else
            return FP_NORM;
    endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Valid/ready operand and result channels of the FP multiply unit.
interface fp_mul_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
);
    import fp_pkg::*;

    localparam int W = fp_w(EXP_W, MAN_W);

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_result;
    logic [TAG_W-1:0] out_tag;
    logic [FLAG_W-1:0] out_flags;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_flags
    );

endinterface

// File: rtl/fp_round_pack.sv
// Combinational round/saturate/pack for a normalised product; RNE when FPMUL_RNE_EN
// is defined, otherwise truncation with no incrementer.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                          sign,
    input  logic signed [EXP_W+1:0]       exp_in,
    input  logic [MAN_W-1:0]              man,
    input  logic                          guard,
    input  logic                          sticky,
    output logic [fp_w(EXP_W, MAN_W)-1:0] result,
    output logic                          of_flag,
    output logic                          uf_flag,
    output logic                          nx_flag
);

    localparam logic signed [EXP_W+1:0] EMAX_S = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [EXP_W+1:0] ZERO_S = '0;

    logic [MAN_W:0]          man_rnd;
    logic signed [EXP_W+1:0] exp_rnd;

`ifdef FPMUL_RNE_EN
    logic inc;
    assign inc     = guard & (sticky | man[0]);
    assign man_rnd = {1'b0, man} + {{MAN_W{1'b0}}, inc};
`else
    assign man_rnd = {1'b0, man};
`endif

    // A carry out of the mantissa leaves the field at zero and bumps the exponent.
    assign exp_rnd = exp_in + $signed({{(EXP_W+1){1'b0}}, man_rnd[MAN_W]});

    always_comb begin
        nx_flag = guard | sticky;
        of_flag = 1'b0;
        uf_flag = 1'b0;
        result  = {sign, exp_rnd[EXP_W-1:0], man_rnd[MAN_W-1:0]};
        if (exp_rnd >= EMAX_S) begin
            result  = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            of_flag = 1'b1;
            nx_flag = 1'b1;
        end else if (exp_rnd <= ZERO_S) begin
            result  = {sign, {(EXP_W+MAN_W){1'b0}}};
            uf_flag = 1'b1;
            nx_flag = 1'b1;
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined FP multiplier (classify / multiply / round) with a global
// advance enable for backpressure. Rounding mode selected by FPMUL_RNE_EN.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_mul_pipe_if.slave bus
);

    localparam int W      = fp_w(EXP_W, MAN_W);
    localparam int XW     = EXP_W + 2;
    localparam int PROD_W = 2 * MAN_W + 2;
    localparam logic signed [XW-1:0] BIAS_S = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] ONE_S  = 1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic adv;
    logic out_valid_reg;

    // Whole pipe freezes when the held result is not being taken.
    assign adv          = ~out_valid_reg | bus.out_ready;
    assign bus.in_ready = adv;

    // ---------------- S1: unpack, classify, exponent sum ----------------
    logic [W-1:0]     opnd [2];
    logic [1:0]       sgn;
    logic [EXP_W-1:0] expf [2];
    logic [MAN_W:0]   sig  [2];
    fp_class_t        cls  [2];

    assign opnd[0] = bus.in_a;
    assign opnd[1] = bus.in_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            assign sgn[gi]  = opnd[gi][W-1];
            assign expf[gi] = opnd[gi][W-2 -: EXP_W];
            assign sig[gi]  = {1'b1, opnd[gi][MAN_W-1:0]};
            assign cls[gi]  = fp_classify(expf[gi] == '0, &expf[gi],
                                          opnd[gi][MAN_W-1:0] == '0);
        end
    endgenerate

    logic              prod_sign;
    logic              spec_hit;
    logic [W-1:0]      spec_result;
    logic [FLAG_W-1:0] spec_flags;
    logic signed [XW-1:0] exp_sum;

    assign prod_sign = sgn[0] ^ sgn[1];
    assign exp_sum   = $signed({2'b00, expf[0]}) + $signed({2'b00, expf[1]}) - BIAS_S;

    always_comb begin
        spec_hit    = 1'b1;
        spec_result = '0;
        spec_flags  = '0;
        if (cls[0] == FP_NAN || cls[1] == FP_NAN) begin
            spec_result = QNAN;
        end else if ((cls[0] == FP_INF && cls[1] == FP_ZERO) ||
                     (cls[0] == FP_ZERO && cls[1] == FP_INF)) begin
            spec_result         = QNAN;
            spec_flags[FLAG_NV] = 1'b1;
        end else if (cls[0] == FP_INF || cls[1] == FP_INF) begin
            spec_result = {prod_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (cls[0] == FP_ZERO || cls[1] == FP_ZERO) begin
            spec_result = {prod_sign, {(W-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    logic              s1_valid_reg, s1_sign_reg, s1_special_reg;
    logic signed [XW-1:0] s1_exp_reg;
    logic [MAN_W:0]    s1_man_a_reg, s1_man_b_reg;
    logic [W-1:0]      s1_spec_result_reg;
    logic [FLAG_W-1:0] s1_spec_flags_reg;
    logic [TAG_W-1:0]  s1_tag_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg       <= 1'b0;
            s1_sign_reg        <= 1'b0;
            s1_special_reg     <= 1'b0;
            s1_exp_reg         <= '0;
            s1_man_a_reg       <= '0;
            s1_man_b_reg       <= '0;
            s1_spec_result_reg <= '0;
            s1_spec_flags_reg  <= '0;
            s1_tag_reg         <= '0;
        end else if (adv) begin
            s1_valid_reg       <= bus.in_valid;
            s1_sign_reg        <= prod_sign;
            s1_special_reg     <= spec_hit;
            s1_exp_reg         <= exp_sum;
            s1_man_a_reg       <= sig[0];
            s1_man_b_reg       <= sig[1];
            s1_spec_result_reg <= spec_result;
            s1_spec_flags_reg  <= spec_flags;
            s1_tag_reg         <= bus.in_tag;
        end
    end

    // ---------------- S2: mantissa product ----------------
    logic              s2_valid_reg, s2_sign_reg, s2_special_reg;
    logic signed [XW-1:0] s2_exp_reg;
    logic [PROD_W-1:0] s2_prod_reg;
    logic [W-1:0]      s2_spec_result_reg;
    logic [FLAG_W-1:0] s2_spec_flags_reg;
    logic [TAG_W-1:0]  s2_tag_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg       <= 1'b0;
            s2_sign_reg        <= 1'b0;
            s2_special_reg     <= 1'b0;
            s2_exp_reg         <= '0;
            s2_prod_reg        <= '0;
            s2_spec_result_reg <= '0;
            s2_spec_flags_reg  <= '0;
            s2_tag_reg         <= '0;
        end else if (adv) begin
            s2_valid_reg       <= s1_valid_reg;
            s2_sign_reg        <= s1_sign_reg;
            s2_special_reg     <= s1_special_reg;
            s2_exp_reg         <= s1_exp_reg;
            s2_prod_reg        <= PROD_W'(s1_man_a_reg) * PROD_W'(s1_man_b_reg);
            s2_spec_result_reg <= s1_spec_result_reg;
            s2_spec_flags_reg  <= s1_spec_flags_reg;
            s2_tag_reg         <= s1_tag_reg;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [MAN_W-1:0]     norm_man;
    logic                 norm_guard, norm_sticky;
    logic signed [XW-1:0] norm_exp;

    always_comb begin
        if (s2_prod_reg[PROD_W-1]) begin
            norm_man    = s2_prod_reg[PROD_W-2 -: MAN_W];
            norm_guard  = s2_prod_reg[MAN_W];
            norm_sticky = |s2_prod_reg[MAN_W-1:0];
            norm_exp    = s2_exp_reg + ONE_S;
        end else begin
            norm_man    = s2_prod_reg[PROD_W-3 -: MAN_W];
            norm_guard  = s2_prod_reg[MAN_W-1];
            norm_sticky = |s2_prod_reg[MAN_W-2:0];
            norm_exp    = s2_exp_reg;
        end
    end

    logic [W-1:0]      rp_result;
    logic              rp_of, rp_uf, rp_nx;
    logic [FLAG_W-1:0] rp_flags;

    fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
        .sign    (s2_sign_reg),
        .exp_in  (norm_exp),
        .man     (norm_man),
        .guard   (norm_guard),
        .sticky  (norm_sticky),
        .result  (rp_result),
        .of_flag (rp_of),
        .uf_flag (rp_uf),
        .nx_flag (rp_nx)
    );

    always_comb begin
        rp_flags          = '0;
        rp_flags[FLAG_OF] = rp_of;
        rp_flags[FLAG_UF] = rp_uf;
        rp_flags[FLAG_NX] = rp_nx;
    end

    logic [W-1:0]      out_result_reg;
    logic [TAG_W-1:0]  out_tag_reg;
    logic [FLAG_W-1:0] out_flags_reg;

    // Output data only loads on a valid stage so bubbles never expose junk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
            out_tag_reg    <= '0;
            out_flags_reg  <= '0;
        end else if (adv) begin
            out_valid_reg <= s2_valid_reg;
            if (s2_valid_reg) begin
                out_result_reg <= s2_special_reg ? s2_spec_result_reg : rp_result;
                out_flags_reg  <= s2_special_reg ? s2_spec_flags_reg : rp_flags;
                out_tag_reg    <= s2_tag_reg;
            end
        end
    end

    assign bus.out_valid  = out_valid_reg;
    assign bus.out_result = out_result_reg;
    assign bus.out_tag    = out_tag_reg;
    assign bus.out_flags  = out_flags_reg;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe (single precision): directed corner cases,
// backpressure stream, randomized ops against a remainder-based reference, reset flush.
module tb_fp_mul_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) bus ();

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] q_a [$];
    logic [31:0] q_b [$];
    logic [3:0]  q_tag [$];
    logic [31:0] q_res [$];
    logic [3:0]  q_flg [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Reference: exact integer product, then round by comparing the remainder to half an ulp.
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, e, sh;
        longint ma, mb, prod, kept, rem, half;
        logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, nx;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s = a[31] ^ b[31];
        a_nan = (ea == 255) && (a[22:0] != 0);
        b_nan = (eb == 255) && (b[22:0] != 0);
        a_inf = (ea == 255) && (a[22:0] == 0);
        b_inf = (eb == 255) && (b[22:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan) return {4'b0000, 32'h7FC00000};
        if ((a_inf && b_zero) || (b_inf && a_zero)) return {4'b1000, 32'h7FC00000};
        if (a_inf || b_inf) return {4'b0000, s, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {4'b0000, s, 31'd0};
        ma = longint'(a[22:0]) + (longint'(1) << 23);
        mb = longint'(b[22:0]) + (longint'(1) << 23);
        prod = ma * mb;
        sh = (prod >= (longint'(1) << 47)) ? 24 : 23;
        e = ea + eb - 127 + (sh - 23);
        kept = prod >> sh;
        rem = prod - (kept << sh);
        half = longint'(1) << (sh - 1);
        nx = (rem != 0);
`ifdef FPMUL_RNE_EN
        if (rem > half || (rem == half && kept[0])) kept = kept + 1;
        if (kept == (longint'(1) << 24)) begin
            kept = kept >> 1;
            e = e + 1;
        end
`endif
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
        if (e <= 0) return {4'b0011, s, 31'd0};
        return {3'b000, nx, s, e[7:0], kept[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] ex;
        logic [22:0] mn;
        int sel;
        sel = int'($urandom_range(0, 15));
        mn = 23'($urandom);
        if (sel == 0) ex = 8'd0;
        else if (sel == 1) begin ex = 8'hFF; mn = '0; end
        else if (sel == 2) begin ex = 8'hFF; mn = mn | 23'd1; end
        else if (sel == 3) ex = 8'($urandom_range(1, 254));
        else ex = 8'($urandom_range(100, 154));
        return {1'($urandom), ex, mn};
    endfunction

    task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                           input logic [31:0] res, input logic [3:0] flg);
        q_a.push_back(a);
        q_b.push_back(b);
        q_tag.push_back(tag);
        q_res.push_back(res);
        q_flg.push_back(flg);
    endtask

    task automatic push_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        logic [35:0] r;
        r = ref_mul(a, b);
        push_op(a, b, tag, r[31:0], r[35:32]);
    endtask

    // Drives queued ops and consumes results cycle by cycle, checking order, hold and latency.
    task automatic run_ops(input int stall_from, input int stall_len, input bit rand_bp,
                           input bit check_lat);
        int n, sent, got, cyc, acc_cyc, drops;
        bit held;
        logic [31:0] h_res;
        logic [3:0] h_tag, h_flg;
        n = q_a.size();
        sent = 0; got = 0; cyc = 0; acc_cyc = 0; drops = 0; held = 0;
        h_res = '0; h_tag = '0; h_flg = '0;
        while (got < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc >= stall_from && cyc < stall_from + stall_len) bus.out_ready = 1'b0;
            else if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
            else bus.out_ready = 1'b1;
            bus.in_valid = (sent < n);
            if (sent < n) begin
                bus.in_a = q_a[sent];
                bus.in_b = q_b[sent];
                bus.in_tag = q_tag[sent];
            end
            #1;
            chk("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
            if (!bus.in_ready) drops++;
            if (held) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_result", bus.out_result, h_res);
                chk("hold_tag", 32'(bus.out_tag), 32'(h_tag));
                chk("hold_flags", 32'(bus.out_flags), 32'(h_flg));
            end
            if (bus.out_valid) begin
                if (check_lat && got == 0) chk("latency", 32'(cyc - acc_cyc), 32'd3);
                if (bus.out_ready) begin
                    chk($sformatf("result[%0d]", got), bus.out_result, q_res[got]);
                    chk($sformatf("flags[%0d]", got), 32'(bus.out_flags), 32'(q_flg[got]));
                    chk($sformatf("tag[%0d]", got), 32'(bus.out_tag), 32'(q_tag[got]));
                    got++;
                end
            end
            held = bus.out_valid && !bus.out_ready;
            h_res = bus.out_result;
            h_tag = bus.out_tag;
            h_flg = bus.out_flags;
            if (bus.in_valid && bus.in_ready) begin
                if (sent == 0) acc_cyc = cyc;
                sent++;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("drained", 32'(got), 32'(n));
        if (stall_len > 0) chk("in_ready_dropped", 32'(drops > 0), 32'd1);
        repeat (4) @(negedge clk);
        #1;
        chk("no_extra_output", 32'(bus.out_valid), 32'd0);
        q_a.delete(); q_b.delete(); q_tag.delete(); q_res.delete(); q_flg.delete();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_tag = '0;
        bus.out_ready = 1'b1;

        // Reset state.
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_result", bus.out_result, 32'd0);
        chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
        chk("rst_out_flags", 32'(bus.out_flags), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed corner cases with spec-given expectations.
        push_op(32'h40000000, 32'h40400000, 4'd0, 32'h40C00000, 4'b0000);
`ifdef FPMUL_RNE_EN
        push_op(32'h3FC00001, 32'h3FC00001, 4'd1, 32'h40100002, 4'b0001);
`else
        push_op(32'h3FC00001, 32'h3FC00001, 4'd1, 32'h40100001, 4'b0001);
`endif
        push_op(32'h7F000000, 32'h7F000000, 4'd2, 32'h7F800000, 4'b0101);
        push_op(32'h00800000, 32'h00800000, 4'd3, 32'h00000000, 4'b0011);
        push_op(32'h7F800000, 32'h00000000, 4'd4, 32'h7FC00000, 4'b1000);
        push_op(32'hFF800000, 32'h40000000, 4'd5, 32'hFF800000, 4'b0000);
        run_ops(1000, 0, 1'b0, 1'b1);

        // Six-op stream with out_ready held low for 5 cycles mid-stream.
        for (int i = 0; i < 6; i++) push_model(rand_fp(), rand_fp(), 4'(i));
        run_ops(5, 5, 1'b0, 1'b0);

        // Randomized operands under random backpressure.
        for (int i = 0; i < 200; i++) push_model(rand_fp(), rand_fp(), 4'(i));
        run_ops(1000, 0, 1'b1, 1'b0);

        // Reset with three ops in flight.
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a = 32'h40000000;
            bus.in_b = 32'h40400000;
            bus.in_tag = 4'(i + 8);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #1;
        chk("inflight_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_out_result", bus.out_result, 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("no_stale[%0d]", i), 32'(bus.out_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
